// File: rtl/mult_display_ctrl.sv
// -----------------------------------------------------------------------------
// mult_display_ctrl
//
// Time-multiplexed 4-digit, 7-segment hex display driver for a 16-bit
// multiplier product. A load strobe captures the product and starts (or
// restarts) a continuous scan: each digit is enabled for REFRESH_DIV clock
// cycles, least-significant nibble first. Leading zeros above digit 0 are
// suppressed, and a registered blank request dark-blanks the display without
// disturbing the scan timing.
//
// Parameters
//   REFRESH_DIV : clock cycles each digit is held (1..65535)
//
// Ports
//   clk        : single clock, rising edge
//   reset_a    : asynchronous active-low reset
//   load       : one-cycle strobe, captures data_in and restarts the scan
//   data_in    : 16-bit product to display
//   blank_en   : blank request (takes effect one cycle later)
//   digit_sel  : one-hot active-high digit enable, bit 0 = LS nibble
//   seg        : {a,b,c,d,e,f,g}, active-high
//   frame_done : one-cycle pulse when the scan wraps from digit 3 to digit 0
//   scanning   : high while scanning
//
// All outputs are registers; they are loaded from the next-state values so
// that the digit belonging to a state is visible in the same cycle the state
// is.
// -----------------------------------------------------------------------------
module mult_display_ctrl #(
  parameter int unsigned REFRESH_DIV = 4
) (
  input  logic        clk,
  input  logic        reset_a,
  input  logic        load,
  input  logic [15:0] data_in,
  input  logic        blank_en,
  output logic [3:0]  digit_sel,
  output logic [6:0]  seg,
  output logic        frame_done,
  output logic        scanning
);

  localparam logic [15:0] PRESC_LAST = 16'(REFRESH_DIV - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] data_q,  data_d;
  logic [1:0]  idx_q,   idx_d;
  logic [15:0] presc_q, presc_d;
  logic        blank_q;
  logic        wrap_d;
  logic [3:0]  sel_d;
  logic [6:0]  seg_d;

  // Hex to seven-segment, {a,b,c,d,e,f,g}, active-high.
  function automatic logic [6:0] hex7(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0:    s = 7'h7E;
      4'h1:    s = 7'h30;
      4'h2:    s = 7'h6D;
      4'h3:    s = 7'h79;
      4'h4:    s = 7'h33;
      4'h5:    s = 7'h5B;
      4'h6:    s = 7'h5F;
      4'h7:    s = 7'h70;
      4'h8:    s = 7'h7F;
      4'h9:    s = 7'h7B;
      4'hA:    s = 7'h77;
      4'hB:    s = 7'h1F;
      4'hC:    s = 7'h4E;
      4'hD:    s = 7'h3D;
      4'hE:    s = 7'h4F;
      default: s = 7'h47;
    endcase
    return s;
  endfunction

  function automatic logic [3:0] onehot(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

  function automatic logic [3:0] nibble_of(input logic [15:0] d, input logic [1:0] idx);
    return d[{idx, 2'b00} +: 4];
  endfunction

  // A digit above 0 is a leading zero when it and every higher nibble are 0.
  function automatic logic is_leading_zero(input logic [15:0] d, input logic [1:0] idx);
    logic z;
    case (idx)
      2'd1:    z = (d[15:4]  == 12'h000);
      2'd2:    z = (d[15:8]  == 8'h00);
      2'd3:    z = (d[15:12] == 4'h0);
      default: z = 1'b0;
    endcase
    return z;
  endfunction

  // Next-state logic: load has priority in either state and restarts the
  // scan; in SCAN the prescaler paces digit advance.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    idx_d   = idx_q;
    presc_d = presc_q;
    wrap_d  = 1'b0;
    if (load) begin
      state_d = SCAN;
      data_d  = data_in;
      idx_d   = 2'd0;
      presc_d = 16'd0;
    end else if (state_q == SCAN) begin
      if (presc_q == PRESC_LAST) begin
        presc_d = 16'd0;
        idx_d   = idx_q + 2'd1;
        wrap_d  = (idx_q == 2'd3);
      end else begin
        presc_d = presc_q + 16'd1;
      end
    end
  end

  // Display decode from the next state; blank_en here becomes blank_q at the
  // same edge, so blanking lines up exactly with blank_q being high.
  always_comb begin
    sel_d = 4'b0000;
    seg_d = 7'h00;
    if (state_d == SCAN && !blank_en) begin
      sel_d = onehot(idx_d);
      if (!is_leading_zero(data_d, idx_d))
        seg_d = hex7(nibble_of(data_d, idx_d));
    end
  end

  // ---- state / output register stage ----
  always_ff @(posedge clk or negedge reset_a) begin
    if (!reset_a) begin
      state_q    <= IDLE;
      data_q     <= 16'h0000;
      idx_q      <= 2'd0;
      presc_q    <= 16'd0;
      blank_q    <= 1'b0;
      digit_sel  <= 4'b0000;
      seg        <= 7'h00;
      frame_done <= 1'b0;
      scanning   <= 1'b0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      idx_q      <= idx_d;
      presc_q    <= presc_d;
      blank_q    <= blank_en;
      digit_sel  <= sel_d;
      seg        <= seg_d;
      frame_done <= wrap_d;
      scanning   <= (state_d == SCAN);
    end
  end

endmodule

// File: tb/tb_mult_display_ctrl.sv
module tb_mult_display_ctrl;

  localparam int RD_A = 4;
  localparam int RD_B = 1;

  logic        clk;
  logic        reset_a;
  logic        load;
  logic [15:0] data_in;
  logic        blank_en;

  logic [3:0]  sel_a, sel_b;
  logic [6:0]  seg_a, seg_b;
  logic        fd_a, fd_b;
  logic        sc_a, sc_b;

  int vectors;
  int miscompares;

  // Behavioural model state: loaded flag, displayed data, cycles since the
  // first displayed cycle after load, and the registered blank request.
  bit          m_act;
  logic [15:0] m_data;
  int          m_t;
  bit          m_bq;

  logic [6:0] hex_tbl [16];

  mult_display_ctrl #(.REFRESH_DIV(RD_A)) dut_a (
    .clk(clk), .reset_a(reset_a), .load(load), .data_in(data_in),
    .blank_en(blank_en), .digit_sel(sel_a), .seg(seg_a),
    .frame_done(fd_a), .scanning(sc_a)
  );

  mult_display_ctrl #(.REFRESH_DIV(RD_B)) dut_b (
    .clk(clk), .reset_a(reset_a), .load(load), .data_in(data_in),
    .blank_en(blank_en), .digit_sel(sel_b), .seg(seg_b),
    .frame_done(fd_b), .scanning(sc_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Expected {sel, seg, frame_done, scanning} for a given refresh divider.
  function automatic logic [12:0] model_out(input int rd);
    logic [3:0] s;
    logic [6:0] g;
    logic       f;
    int         idx;
    int         rest;
    s = 4'b0000;
    g = 7'h00;
    f = 1'b0;
    if (m_act) begin
      idx  = (m_t / rd) % 4;
      f    = (m_t > 0) && (m_t % (4 * rd) == 0);
      rest = int'(m_data) >> (4 * idx);
      if (!m_bq) begin
        s = 4'(1 << idx);
        if (idx == 0 || rest != 0) g = hex_tbl[rest % 16];
      end
    end
    return {s, g, f, m_act ? 1'b1 : 1'b0};
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  task automatic check_model();
    logic [12:0] ea, eb;
    ea = model_out(RD_A);
    eb = model_out(RD_B);
    check("a.state", {3'b0, sel_a, seg_a, fd_a, sc_a}, {3'b0, ea});
    check("b.state", {3'b0, sel_b, seg_b, fd_b, sc_b}, {3'b0, eb});
  endtask

  // One clock: update the model with the inputs seen at the edge, then compare.
  task automatic step();
    @(posedge clk);
    if (!reset_a) begin
      m_act = 0; m_data = 16'h0; m_t = 0; m_bq = 0;
    end else begin
      if (load) begin
        m_act = 1; m_data = data_in; m_t = 0;
      end else if (m_act) begin
        m_t++;
      end
      m_bq = blank_en;
    end
    #1;
    check_model();
  endtask

  task automatic do_load(input logic [15:0] d);
    load = 1'b1;
    data_in = d;
    step();
    load = 1'b0;
  endtask

  typedef struct {
    logic        ld;
    logic [15:0] din;
    logic        blk;
    int          n;
    logic [3:0]  sel;
    logic [6:0]  sg;
    logic        fd;
  } vec_t;

  vec_t tbl[$];

  initial begin
    int fd_count;
    vectors = 0;
    miscompares = 0;
    hex_tbl = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};
    m_act = 0; m_data = 16'h0; m_t = 0; m_bq = 0;

    reset_a = 1'b0; load = 1'b0; data_in = 16'h0; blank_en = 1'b0;

    // table: {load, data, blank, cycles, exp sel, exp seg, exp frame_done}
    tbl.push_back('{1'b1, 16'h12AF, 1'b0, 1, 4'b0001, 7'h47, 1'b0});
    tbl.push_back('{1'b0, 16'h0000, 1'b0, 3, 4'b0001, 7'h47, 1'b0});
    tbl.push_back('{1'b0, 16'h0000, 1'b0, 1, 4'b0010, 7'h77, 1'b0});
    tbl.push_back('{1'b0, 16'h0000, 1'b0, 4, 4'b0100, 7'h6D, 1'b0});
    tbl.push_back('{1'b0, 16'h0000, 1'b0, 4, 4'b1000, 7'h30, 1'b0});
    tbl.push_back('{1'b0, 16'h0000, 1'b0, 3, 4'b1000, 7'h30, 1'b0});
    tbl.push_back('{1'b0, 16'h0000, 1'b0, 1, 4'b0001, 7'h47, 1'b1});
    tbl.push_back('{1'b0, 16'h0000, 1'b0, 1, 4'b0001, 7'h47, 1'b0});
    tbl.push_back('{1'b1, 16'h0005, 1'b0, 1, 4'b0001, 7'h5B, 1'b0});
    tbl.push_back('{1'b0, 16'h0000, 1'b0, 4, 4'b0010, 7'h00, 1'b0});
    tbl.push_back('{1'b0, 16'h0000, 1'b0, 4, 4'b0100, 7'h00, 1'b0});
    tbl.push_back('{1'b0, 16'h0000, 1'b0, 4, 4'b1000, 7'h00, 1'b0});
    tbl.push_back('{1'b1, 16'h0000, 1'b0, 1, 4'b0001, 7'h7E, 1'b0});
    tbl.push_back('{1'b0, 16'h0000, 1'b0, 4, 4'b0010, 7'h00, 1'b0});
    tbl.push_back('{1'b1, 16'h0F00, 1'b0, 1, 4'b0001, 7'h7E, 1'b0});
    tbl.push_back('{1'b0, 16'h0000, 1'b0, 4, 4'b0010, 7'h7E, 1'b0});
    tbl.push_back('{1'b0, 16'h0000, 1'b0, 4, 4'b0100, 7'h47, 1'b0});
    tbl.push_back('{1'b0, 16'h0000, 1'b0, 4, 4'b1000, 7'h00, 1'b0});
    tbl.push_back('{1'b1, 16'hBEEF, 1'b1, 1, 4'b0000, 7'h00, 1'b0});
    tbl.push_back('{1'b0, 16'h0000, 1'b0, 1, 4'b0001, 7'h47, 1'b0});

    // Reset state before any clock edge.
    #2;
    check("rst.outputs", {3'b0, sel_a, seg_a, fd_a, sc_a}, 16'h0000);
    load = 1'b1; data_in = 16'h1234;
    step();
    step();
    load = 1'b0;
    reset_a = 1'b1;

    // Idle with no load: nothing shows, no frame_done.
    fd_count = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (fd_a || fd_b) fd_count++;
    end
    check("idle.frame_done", 16'(fd_count), 16'd0);
    check("idle.scanning", {15'b0, sc_a}, 16'd0);

    // Table-driven vectors against the RD=4 instance.
    foreach (tbl[k]) begin
      load = tbl[k].ld; data_in = tbl[k].din; blank_en = tbl[k].blk;
      step();
      load = 1'b0; blank_en = 1'b0;
      for (int j = 1; j < tbl[k].n; j++) step();
      check($sformatf("tbl%0d.sel", k), {12'b0, sel_a}, {12'b0, tbl[k].sel});
      check($sformatf("tbl%0d.seg", k), {9'b0, seg_a}, {9'b0, tbl[k].sg});
      check($sformatf("tbl%0d.fd", k), {15'b0, fd_a}, {15'b0, tbl[k].fd});
    end

    // Mid-frame reload at digit 2: restart at digit 0, no frame_done for the
    // aborted frame, first pulse after one full new frame.
    do_load(16'hFFFF);
    for (int i = 0; i < 9; i++) step();
    check("mid.at_digit2", {12'b0, sel_a}, 16'h0004);
    do_load(16'h0123);
    check("mid.sel", {12'b0, sel_a}, 16'h0001);
    check("mid.seg", {9'b0, seg_a}, 16'h0079);
    fd_count = 0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (fd_a) fd_count++;
    end
    check("mid.no_early_fd", 16'(fd_count), 16'd0);
    step();
    check("mid.fd_full_frame", {15'b0, fd_a}, 16'd1);

    // Blanking for 10 cycles mid-scan.
    do_load(16'h12AF);
    for (int i = 0; i < 5; i++) step();
    blank_en = 1'b1;
    fd_count = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (sel_a != 4'b0000 || seg_a != 7'h00) fd_count++;
    end
    check("blank.dark_cycles", 16'(fd_count), 16'd0);
    blank_en = 1'b0;
    step();
    check("blank.resume_sel", {12'b0, sel_a}, 16'h0001);
    check("blank.resume_seg", {9'b0, seg_a}, 16'h0047);
    check("blank.resume_fd", {15'b0, fd_a}, 16'd1);

    // Asynchronous reset between clock edges mid-scan.
    do_load(16'hA5C3);
    for (int i = 0; i < 6; i++) step();
    #2;
    reset_a = 1'b0;
    #1;
    m_act = 0; m_data = 16'h0; m_t = 0; m_bq = 0;
    check("arst.a", {3'b0, sel_a, seg_a, fd_a, sc_a}, 16'h0000);
    check("arst.b", {3'b0, sel_b, seg_b, fd_b, sc_b}, 16'h0000);
    step();
    reset_a = 1'b1;
    for (int i = 0; i < 10; i++) step();
    check("arst.stay_idle", {15'b0, sc_a}, 16'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      load = ($urandom_range(0, 19) == 0);
      case ($urandom_range(0, 3))
        0:       data_in = 16'($urandom_range(0, 15));
        1:       data_in = 16'($urandom_range(0, 255));
        2:       data_in = 16'($urandom_range(0, 4095));
        default: data_in = 16'($urandom);
      endcase
      if ($urandom_range(0, 7) == 0) blank_en = ~blank_en;
      step();
    end
    load = 1'b0;
    blank_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
